// File: rtl/kbd_event_pkg.sv
// Shared definitions for the keyboard event decoder: scan-code constants,
// prefix FSM encoding and the queued event record.
package kbd_event_pkg;

  localparam logic [7:0] SC_EXT    = 8'hE0;
  localparam logic [7:0] SC_BRK    = 8'hF0;
  localparam logic [7:0] SC_LSHIFT = 8'h12;
  localparam logic [7:0] SC_RSHIFT = 8'h59;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    EXT     = 2'd1,
    BRK     = 2'd2,
    EXT_BRK = 2'd3
  } state_t;

  typedef struct packed {
    logic       make;
    logic       ext;
    logic [7:0] code;
    logic [7:0] ascii;
  } kbd_ev_t;

endpackage

// File: rtl/kbd_event_scan_to_ascii.sv
// Combinational set-2 scan code to ASCII lookup; unmapped codes give 8'h00.
module scan_to_ascii (
  input  logic [7:0] code,
  input  logic       shifted,
  output logic [7:0] ascii
);

  logic [7:0] base;

  always_comb begin
    base  = shifted ? 8'h41 : 8'h61;
    ascii = 8'h00;
    case (code)
      8'h1C: ascii = base + 8'd0;
      8'h32: ascii = base + 8'd1;
      8'h21: ascii = base + 8'd2;
      8'h23: ascii = base + 8'd3;
      8'h24: ascii = base + 8'd4;
      8'h2B: ascii = base + 8'd5;
      8'h34: ascii = base + 8'd6;
      8'h33: ascii = base + 8'd7;
      8'h43: ascii = base + 8'd8;
      8'h3B: ascii = base + 8'd9;
      8'h42: ascii = base + 8'd10;
      8'h4B: ascii = base + 8'd11;
      8'h3A: ascii = base + 8'd12;
      8'h31: ascii = base + 8'd13;
      8'h44: ascii = base + 8'd14;
      8'h4D: ascii = base + 8'd15;
      8'h15: ascii = base + 8'd16;
      8'h2D: ascii = base + 8'd17;
      8'h1B: ascii = base + 8'd18;
      8'h2C: ascii = base + 8'd19;
      8'h3C: ascii = base + 8'd20;
      8'h2A: ascii = base + 8'd21;
      8'h1D: ascii = base + 8'd22;
      8'h22: ascii = base + 8'd23;
      8'h35: ascii = base + 8'd24;
      8'h1A: ascii = base + 8'd25;
      // Digits ignore shift: symbols on the number row are not decoded.
      8'h45: ascii = 8'h30;
      8'h16: ascii = 8'h31;
      8'h1E: ascii = 8'h32;
      8'h26: ascii = 8'h33;
      8'h25: ascii = 8'h34;
      8'h2E: ascii = 8'h35;
      8'h36: ascii = 8'h36;
      8'h3D: ascii = 8'h37;
      8'h3E: ascii = 8'h38;
      8'h46: ascii = 8'h39;
      8'h29: ascii = 8'h20;
      8'h5A: ascii = 8'h0D;
      8'h66: ascii = 8'h08;
      default: ascii = 8'h00;
    endcase
  end

endmodule

// File: rtl/kbd_event.sv
// Keyboard event decoder: strips E0/F0 prefixes, filters typematic repeats,
// tracks shift, translates to ASCII and queues events in a small FIFO.
module kbd_event
  import kbd_event_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       scan_valid,
  input  logic [7:0] scan_data,
  output logic       ev_valid,
  input  logic       ev_ready,
  output logic       ev_make,
  output logic       ev_ext,
  output logic [7:0] ev_code,
  output logic [7:0] ev_ascii,
  output logic [7:0] press_count,
  output logic       overflow
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = DEPTH[AW:0];

  state_t     state;
  logic       lshift, rshift;
  logic       held_vld, held_ext;
  logic [7:0] held_code;
  kbd_ev_t    mem [DEPTH];
  logic [AW-1:0] rd_ptr, wr_ptr;
  logic [AW:0]   count;

  logic       formed, new_make, new_ext, shifted, held_match, is_repeat, emit;
  logic       full, pop, push;
  logic [7:0] lut_ascii;
  kbd_ev_t    new_ev;

  scan_to_ascii u_lut (
    .code   (scan_data),
    .shifted(shifted),
    .ascii  (lut_ascii)
  );

  always_comb begin
    formed     = scan_valid && (scan_data != SC_EXT) && (scan_data != SC_BRK);
    new_make   = !((state == BRK) || (state == EXT_BRK));
    new_ext    = (state == EXT) || (state == EXT_BRK);
    shifted    = lshift | rshift;
    held_match = held_vld && (held_ext == new_ext) && (held_code == scan_data);
    is_repeat  = new_make && held_match;
    emit       = formed && !is_repeat;
    new_ev.make  = new_make;
    new_ev.ext   = new_ext;
    new_ev.code  = scan_data;
    new_ev.ascii = new_ext ? 8'h00 : lut_ascii;
  end

  // Handshake: the head entry transfers on any cycle where ev_valid and
  // ev_ready are both high; ev_ready while empty is ignored. A push into a
  // full FIFO is accepted only when that same cycle also pops.
  always_comb begin
    full = (count == FULL_CNT);
    pop  = ev_valid && ev_ready;
    push = emit && (!full || pop);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else if (scan_valid) begin
      if (scan_data == SC_EXT) begin
        state <= (state == EXT_BRK) ? EXT_BRK : EXT;
      end else if (scan_data == SC_BRK) begin
        state <= (state == EXT || state == EXT_BRK) ? EXT_BRK : BRK;
      end else begin
        state <= IDLE;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      lshift      <= 1'b0;
      rshift      <= 1'b0;
      held_vld    <= 1'b0;
      held_ext    <= 1'b0;
      held_code   <= 8'h00;
      press_count <= 8'h00;
      overflow    <= 1'b0;
    end else begin
      if (formed && !new_ext && scan_data == SC_LSHIFT) lshift <= new_make;
      if (formed && !new_ext && scan_data == SC_RSHIFT) rshift <= new_make;
      if (emit && new_make) begin
        held_vld    <= 1'b1;
        held_ext    <= new_ext;
        held_code   <= scan_data;
        press_count <= press_count + 8'd1;
      end else if (formed && !new_make && held_match) begin
        held_vld <= 1'b0;
      end
      if (emit && full && !pop) overflow <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= new_ev;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_comb begin
    ev_valid = (count != '0);
    ev_make  = mem[rd_ptr].make;
    ev_ext   = mem[rd_ptr].ext;
    ev_code  = mem[rd_ptr].code;
    ev_ascii = mem[rd_ptr].ascii;
  end

endmodule

// File: tb/tb_kbd_event.sv
// Directed table-driven bench for kbd_event plus hand-written sequences for
// FIFO overflow, full-with-pop and reset during a pending prefix.
module tb_kbd_event;
  import kbd_event_pkg::*;

  logic       clk = 1'b0;
  logic       reset, scan_valid, ev_ready;
  logic [7:0] scan_data;
  logic       ev_valid, ev_make, ev_ext, overflow;
  logic [7:0] ev_code, ev_ascii, press_count;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [7:0] sc;
    logic       v;
    kbd_ev_t    ev;
    logic [7:0] cnt;
  } vec_t;

  vec_t       vecs[$];
  logic [7:0] exp_q[$];

  kbd_event #(.DEPTH(4)) dut (
    .clk        (clk),
    .reset      (reset),
    .scan_valid (scan_valid),
    .scan_data  (scan_data),
    .ev_valid   (ev_valid),
    .ev_ready   (ev_ready),
    .ev_make    (ev_make),
    .ev_ext     (ev_ext),
    .ev_code    (ev_code),
    .ev_ascii   (ev_ascii),
    .press_count(press_count),
    .overflow   (overflow)
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic do_reset();
    reset = 1'b1;
    scan_valid = 1'b0;
    scan_data = 8'h00;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
  endtask

  task automatic pulse_reset();
    reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
  endtask

  // driver
  task automatic send(input logic [7:0] b);
    scan_valid = 1'b1;
    scan_data  = b;
    @(posedge clk);
    #1;
    scan_valid = 1'b0;
    scan_data  = 8'h00;
  endtask

  // scoreboard
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drain(input string name);
    int n;
    n = 0;
    ev_ready = 1'b1;
    while (exp_q.size() > 0) begin
      check($sformatf("%s_valid%0d", name, n), 32'(ev_valid), 32'd1);
      check($sformatf("%s_ascii%0d", name, n), 32'(ev_ascii), 32'(exp_q.pop_front()));
      @(posedge clk);
      #1;
      n++;
    end
    check($sformatf("%s_empty", name), 32'(ev_valid), 32'd0);
    ev_ready = 1'b0;
  endtask

  task automatic add(input logic [7:0] sc, input logic v, input logic mk, input logic ex,
                     input logic [7:0] code, input logic [7:0] asc, input logic [7:0] cnt);
    vec_t r;
    r.sc  = sc;
    r.v   = v;
    r.ev  = {mk, ex, code, asc};
    r.cnt = cnt;
    vecs.push_back(r);
  endtask

  task automatic add_none(input logic [7:0] sc, input logic [7:0] cnt);
    add(sc, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, cnt);
  endtask

  initial begin
    reset = 1'b1;
    scan_valid = 1'b0;
    scan_data = 8'h00;
    ev_ready = 1'b0;
    do_reset();

    check("rst_valid", 32'(ev_valid), 32'd0);
    check("rst_count", 32'(press_count), 32'd0);
    check("rst_ovf", 32'(overflow), 32'd0);
    check("rst_make", 32'(ev_make), 32'd0);
    check("rst_ext", 32'(ev_ext), 32'd0);
    check("rst_code", 32'(ev_code), 32'd0);
    check("rst_ascii", 32'(ev_ascii), 32'd0);

    // press / release
    add(8'h1C, 1, 1, 0, 8'h1C, 8'h61, 1);
    add_none(8'hF0, 1);
    add(8'h1C, 1, 0, 0, 8'h1C, 8'h61, 1);
    // shifted key
    add(8'h12, 1, 1, 0, 8'h12, 8'h00, 2);
    add(8'h1C, 1, 1, 0, 8'h1C, 8'h41, 3);
    add_none(8'hF0, 3);
    add(8'h1C, 1, 0, 0, 8'h1C, 8'h41, 3);
    add_none(8'hF0, 3);
    add(8'h12, 1, 0, 0, 8'h12, 8'h00, 3);
    // typematic
    add(8'h1C, 1, 1, 0, 8'h1C, 8'h61, 4);
    add_none(8'h1C, 4);
    add_none(8'h1C, 4);
    add_none(8'hF0, 4);
    add(8'h1C, 1, 0, 0, 8'h1C, 8'h61, 4);
    add(8'h1C, 1, 1, 0, 8'h1C, 8'h61, 5);
    // extended
    add_none(8'hE0, 5);
    add(8'h75, 1, 1, 1, 8'h75, 8'h00, 6);
    add_none(8'hE0, 6);
    add_none(8'hF0, 6);
    add(8'h75, 1, 0, 1, 8'h75, 8'h00, 6);
    // special keys and letters
    add(8'h29, 1, 1, 0, 8'h29, 8'h20, 7);
    add(8'h5A, 1, 1, 0, 8'h5A, 8'h0D, 8);
    add(8'h66, 1, 1, 0, 8'h66, 8'h08, 9);
    add(8'h4D, 1, 1, 0, 8'h4D, 8'h70, 10);
    // right shift, shift-insensitive digit, extended 12 is not a shift
    add(8'h59, 1, 1, 0, 8'h59, 8'h00, 11);
    add(8'h1A, 1, 1, 0, 8'h1A, 8'h5A, 12);
    add(8'h45, 1, 1, 0, 8'h45, 8'h30, 13);
    add_none(8'hE0, 13);
    add(8'h12, 1, 1, 1, 8'h12, 8'h00, 14);
    add_none(8'hE0, 14);
    add_none(8'hE0, 14);
    add(8'h6B, 1, 1, 1, 8'h6B, 8'h00, 15);
    add_none(8'hF0, 15);
    add_none(8'hF0, 15);
    add(8'h59, 1, 0, 0, 8'h59, 8'h00, 15);
    add(8'h1A, 1, 1, 0, 8'h1A, 8'h7A, 16);
    add_none(8'h1A, 16);
    add_none(8'hE0, 16);
    add(8'h1A, 1, 1, 1, 8'h1A, 8'h00, 17);
    add_none(8'hE0, 17);
    add_none(8'hF0, 17);
    add_none(8'hE0, 17);
    add(8'h6B, 1, 0, 1, 8'h6B, 8'h00, 17);
    add(8'h76, 1, 1, 0, 8'h76, 8'h00, 18);

    ev_ready = 1'b1;
    for (int i = 0; i < vecs.size(); i++) begin
      send(vecs[i].sc);
      check($sformatf("vec%0d_valid", i), 32'(ev_valid), 32'(vecs[i].v));
      if (vecs[i].v) begin
        check($sformatf("vec%0d_make", i), 32'(ev_make), 32'(vecs[i].ev.make));
        check($sformatf("vec%0d_ext", i), 32'(ev_ext), 32'(vecs[i].ev.ext));
        check($sformatf("vec%0d_code", i), 32'(ev_code), 32'(vecs[i].ev.code));
        check($sformatf("vec%0d_ascii", i), 32'(ev_ascii), 32'(vecs[i].ev.ascii));
      end
      check($sformatf("vec%0d_count", i), 32'(press_count), 32'(vecs[i].cnt));
    end
    check("tbl_ovf", 32'(overflow), 32'd0);
    ev_ready = 1'b0;

    // overflow with consumer stalled
    do_reset();
    send(8'h16);
    send(8'h1E);
    send(8'h26);
    send(8'h25);
    check("full_no_ovf", 32'(overflow), 32'd0);
    send(8'h2E);
    check("ovf_set", 32'(overflow), 32'd1);
    check("ovf_count", 32'(press_count), 32'd5);
    check("ovf_valid", 32'(ev_valid), 32'd1);
    exp_q.push_back(8'h31);
    exp_q.push_back(8'h32);
    exp_q.push_back(8'h33);
    exp_q.push_back(8'h34);
    drain("ovf_drain");
    check("ovf_sticky", 32'(overflow), 32'd1);

    // full FIFO with a pop in the same cycle as a push
    do_reset();
    check("ovf_rst", 32'(overflow), 32'd0);
    send(8'h16);
    send(8'h1E);
    send(8'h26);
    send(8'h25);
    ev_ready = 1'b1;
    send(8'h2E);
    ev_ready = 1'b0;
    check("fullpop_ovf", 32'(overflow), 32'd0);
    exp_q.push_back(8'h32);
    exp_q.push_back(8'h33);
    exp_q.push_back(8'h34);
    exp_q.push_back(8'h35);
    drain("fullpop_drain");

    // reset while a prefix is pending
    do_reset();
    ev_ready = 1'b1;
    send(8'hF0);
    pulse_reset();
    send(8'h1C);
    check("midrst_valid", 32'(ev_valid), 32'd1);
    check("midrst_make", 32'(ev_make), 32'd1);
    check("midrst_ext", 32'(ev_ext), 32'd0);
    check("midrst_code", 32'(ev_code), 32'h1C);
    check("midrst_ascii", 32'(ev_ascii), 32'h61);
    @(posedge clk);
    #1;
    check("midrst_single", 32'(ev_valid), 32'd0);
    check("midrst_count", 32'(press_count), 32'd1);
    send(8'hE0);
    pulse_reset();
    send(8'h75);
    check("midrst_e0_make", 32'(ev_make), 32'd1);
    check("midrst_e0_ext", 32'(ev_ext), 32'd0);
    check("midrst_e0_code", 32'(ev_code), 32'h75);
    ev_ready = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/kbd_event.md
# kbd_event

Keyboard event decoder that sits directly downstream of the PS/2 receiver. It consumes that receiver's one-cycle-valid scan-code bytes and strips the `E0` (extended) and `F0` (break) prefixes. It suppresses typematic repeats, tracks shift state, translates codes to ASCII, and queues complete key events in a small FIFO drained by a valid/ready consumer (display or CPU MMIO glue).

## Interface
- `DEPTH`, 4: event FIFO entries; power of two, ≥2.
- `clk` input 1: system clock; single clock domain.
- `reset` input 1: synchronous, active-high reset.
- `scan_valid` input 1: one-cycle pulse; `scan_data` is valid this cycle.
- `scan_data` input 8: raw scan-code byte.
- `ev_valid` output 1: FIFO head holds an event.
- `ev_ready` input 1: consumer accepts the head when `ev_valid & ev_ready`.
- `ev_make` output 1: 1 = press, 0 = release.
- `ev_ext` output 1: event was `E0`-prefixed.
- `ev_code` output 8: scan code, with prefixes removed.
- `ev_ascii` output 8: ASCII value, or `8'h00` if unmapped.
- `press_count` output 8: count of accepted non-repeat make events; wraps modulo 256.
- `overflow` output 1: sticky; an event was dropped because the FIFO was full.

## Operation
- Prefix FSM states: `IDLE`, `EXT`, `BRK`, `EXT_BRK`. It advances only on `scan_valid`.
  - `E0` → `EXT` from `IDLE`, `BRK` or `EXT`; `E0` in `EXT_BRK` stays `EXT_BRK`.
  - `F0`: `IDLE`→`BRK`, `EXT`→`EXT_BRK`; stays in `BRK` or `EXT_BRK`.
  - Any other byte forms an event with `make = ~(BRK|EXT_BRK)` and `ext = (EXT|EXT_BRK)`, then FSM → `IDLE`.
- Shift tracking, applied on every formed event before the repeat filter:
  - `lshift` follows code `12`, `rshift` follows code `59`, both non-extended only: set on make, clear on break.
  - `shifted = lshift | rshift`.
- Repeat filter uses registers `held_vld`, `held_ext`, `held_code`.
  - A make event matching the held `{ext, code}` while `held_vld` is set is discarded: no push, no count.
  - Any other make event is emitted and loads the held registers.
  - A break event is always emitted; it clears `held_vld` if it matches the held key.
- ASCII mapping, non-extended codes only; extended codes give `00`:
  - Letters a–z: `1C 32 21 23 24 2B 34 33 43 3B 42 4B 3A 31 44 4D 15 2D 1B 2C 3C 2A 1D 22 35 1A`. Lowercase, or uppercase when `shifted` is sampled at event formation.
  - Digits 0–9: `45 16 1E 26 25 2E 36 3D 3E 46`; unaffected by shift.
  - `29`→`20`, `5A`→`0D`, `66`→`08`; everything else → `00`.
- `press_count` increments on each emitted make event, including shift keys, even if the push is dropped.
- FIFO:
  - Push when an event is emitted.
  - When full with no pop that cycle, the push is dropped and `overflow` is set; `overflow` clears only on `reset`.
  - When full and a pop occurs in the same cycle, the push is accepted and occupancy is unchanged.
  - Pop when `ev_valid & ev_ready`.
  - Outputs `ev_*` reflect the head entry and are undefined-but-stable when `ev_valid` = 0. The bench checks them only under `ev_valid`.

## Timing
- Latency: with the FIFO empty, a terminating byte whose `scan_valid` is at cycle t gives `ev_valid` = 1 at t+1.
- A prefix byte produces no output.
- Back-to-back `scan_valid` on consecutive cycles must be handled, although the upstream block rate is far lower.
- `reset` values:
  - FSM `IDLE`; shift and held registers cleared; FIFO empty.
  - `ev_valid` = 0, `press_count` = 0, `overflow` = 0.
  - `ev_make`/`ev_ext`/`ev_code`/`ev_ascii` read as 0.
- A reset asserted mid-sequence (after `E0`/`F0`) discards the pending prefix.
- `ev_ready` may be held high permanently; it may also be asserted while `ev_valid` = 0, with no effect.

## Structure
- A shared package holds:
  - scan-code constants (`SC_EXT`=`E0`, `SC_BRK`=`F0`, `SC_LSHIFT`=`12`, `SC_RSHIFT`=`59`);
  - the FSM state encoding;
  - the packed event struct `{make, ext, code[7:0], ascii[7:0]}`, 18 bits.
- Sub-module `scan_to_ascii`: purely combinational lookup with inputs `code` and `shifted` and output `ascii`. It is instantiated once at event formation, so the FIFO stores ASCII.
- The FIFO stays inline: a register array plus read/write pointers and a count, `$clog2(DEPTH)+1` bits.

## Test plan
- Press and release, `ev_ready`=1: bytes `1C`, `F0 1C` → events {1,0,1C,61} then {0,0,1C,61}; `press_count`=1.
- Shifted key: `12`, `1C`, `F0 1C`, `F0 12` → the `1C` make and break both give ascii `41`; four events total; `press_count`=2.
- Typematic: `1C 1C 1C F0 1C 1C` → make, break, make (three events); `press_count`=2.
- Extended: `E0 75`, `E0 F0 75` → {1,1,75,00}, {0,1,75,00}.
- Overflow, `DEPTH`=4 and `ev_ready`=0: makes `16 1E 26 25 2E` → four entries, `overflow`=1, `press_count`=5. Then draining yields ascii `31 32 33 34`.
- Reset mid-prefix: `F0`, `reset` pulse, `1C` → a single make event {1,0,1C,61}.
